// File: rtl/mem_bist.sv
// -----------------------------------------------------------------------------
// mem_bist -- march-style memory built-in self test.
//
// For every address from 0 to ADDR_LAST the engine writes the test pattern,
// reads it back and compares the returned word. It counts miscompares, with
// the count saturating at 16'hFFFF, and records the address of the first one.
// Each address takes exactly three cycles (WRITE, READ, CHECK). One FIN cycle
// closes the run.
//
// Optional feature: define MEM_BIST_INVERT_PASS_EN to add a second sweep that
// writes and expects ~PATTERN. The miscompare count accumulates across both
// sweeps. With the macro undefined there is a single sweep and no sweep state.
// -----------------------------------------------------------------------------
module mem_bist #(
  parameter logic [15:0] ADDR_LAST = 16'h1FFF,
  parameter logic [15:0] PATTERN   = 16'hABCD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] fail_count,
  output logic [15:0] fail_addr,
  output logic        memW,
  output logic        memR,
  output logic [15:0] addr_in,
  output logic [15:0] dataW_in,
  input  logic [15:0] mem_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic        memw_q;
  logic        memr_q;
  logic [15:0] addr_q;
  logic [15:0] dataw_q;      // holds the pattern of the sweep in progress
  logic [15:0] fail_cnt_q;
  logic [15:0] fail_addr_q;
`ifdef MEM_BIST_INVERT_PASS_EN
  logic        sweep_q;      // 0: PATTERN sweep, 1: ~PATTERN sweep
`endif

  logic [15:0] fail_cnt_d;
  logic        miscompare;

  // Saturating next value of the miscompare counter.
  always_comb begin
    // NOTE: give every always_comb output a default first, so that no path
    // leaves it unassigned and no latch is inferred.
    fail_cnt_d = fail_cnt_q;
    if (fail_cnt_q != 16'hFFFF) begin
      fail_cnt_d = fail_cnt_q + 16'd1;
    end
  end

  // The read word arrives in CHECK, the cycle after memR. The pattern it is
  // compared against is the one that was written in WRITE.
  assign miscompare = (mem_out != dataw_q);

  // Sequence the test and register all of its outputs.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    if (RST) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      memw_q      <= 1'b0;
      memr_q      <= 1'b0;
      addr_q      <= 16'h0000;
      dataw_q     <= 16'h0000;
      fail_cnt_q  <= 16'h0000;
      fail_addr_q <= 16'h0000;
`ifdef MEM_BIST_INVERT_PASS_EN
      sweep_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= WRITE;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            memw_q      <= 1'b1;
            addr_q      <= 16'h0000;
            dataw_q     <= PATTERN;
            fail_cnt_q  <= 16'h0000;
            fail_addr_q <= 16'h0000;
`ifdef MEM_BIST_INVERT_PASS_EN
            sweep_q     <= 1'b0;
`endif
          end
        end

        WRITE: begin
          state_q <= READ;
          memw_q  <= 1'b0;
          memr_q  <= 1'b1;
        end

        READ: begin
          state_q <= CHECK;
          memr_q  <= 1'b0;
        end

        CHECK: begin
          if (miscompare) begin
            fail_cnt_q <= fail_cnt_d;
            if (fail_cnt_q == 16'h0000) begin
              fail_addr_q <= addr_q;
            end
          end
          // The address is never incremented once it reaches ADDR_LAST, so it
          // cannot wrap even when ADDR_LAST is 16'hFFFF.
          if (addr_q != ADDR_LAST) begin
            state_q <= WRITE;
            memw_q  <= 1'b1;
            addr_q  <= addr_q + 16'd1;
          end
`ifdef MEM_BIST_INVERT_PASS_EN
          else if (!sweep_q) begin
            state_q <= WRITE;
            memw_q  <= 1'b1;
            sweep_q <= 1'b1;
            addr_q  <= 16'h0000;
            dataw_q <= ~PATTERN;
          end
`endif
          else begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        FIN: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          memw_q  <= 1'b0;
          memr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = (fail_cnt_q == 16'h0000);
  assign fail_count = fail_cnt_q;
  assign fail_addr  = fail_addr_q;
  assign memW       = memw_q;
  assign memR       = memr_q;
  assign addr_in    = addr_q;
  assign dataW_in   = dataw_q;

endmodule

// File: tb/tb_mem_bist.sv
// -----------------------------------------------------------------------------
// tb_mem_bist -- scoreboard bench for mem_bist with ADDR_LAST=3.
// The driver pushes the expected outcome of each run. A monitor pops that
// outcome when done rises and compares it with the DUT. The monitor also checks
// the address and data of every memory strobe. A small memory model can apply
// stuck-at faults to individual addresses.
// -----------------------------------------------------------------------------
module tb_mem_bist;

  localparam logic [15:0] LAST = 16'h0003;
  localparam logic [15:0] PAT  = 16'hABCD;
  localparam int          N    = 4;
`ifdef MEM_BIST_INVERT_PASS_EN
  localparam int          SWEEPS = 2;
`else
  localparam int          SWEEPS = 1;
`endif

  logic        CLK, RST, start;
  logic        busy, done, pass, memW, memR;
  logic [15:0] fail_count, fail_addr, addr_in, dataW_in, mem_out;

  mem_bist #(.ADDR_LAST(LAST), .PATTERN(PAT)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .fail_addr(fail_addr),
    .memW(memW), .memR(memR), .addr_in(addr_in),
    .dataW_in(dataW_in), .mem_out(mem_out)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- memory model with per-address stuck-at masks -----------
  logic [15:0] mem   [16];
  logic [15:0] and_m [16];
  logic [15:0] or_m  [16];

  always @(posedge CLK) begin
    if (memW) mem[addr_in[3:0]] <= dataW_in;
    if (memR) mem_out <= (mem[addr_in[3:0]] & and_m[addr_in[3:0]]) | or_m[addr_in[3:0]];
  end

  // ---------------- scoreboard and checking ---------------------------------
  typedef struct {
    string       name;
    logic [15:0] fc;
    logic [15:0] fa;
    logic        ps;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;
  int   busy_cnt  = 0;
  int   wr_idx    = 0;
  logic [15:0] last_wr = 16'h0;

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (busy && !busy_prev) begin
        busy_cnt = 0;
        wr_idx   = 0;
      end
      if (busy) busy_cnt++;
      if (memW && memR) check("strobes_both_high", 32'(memW & memR), 32'd0);
      if (!busy) check("strobes_when_idle", 32'({memW, memR}), 32'd0);
      if (memW) begin
        check("write_addr", 32'(addr_in), 32'(wr_idx % N));
        check("write_data", 32'(dataW_in), (wr_idx >= N) ? 32'(16'(~PAT)) : 32'(PAT));
        last_wr = addr_in;
        wr_idx++;
      end
      if (memR) check("read_addr", 32'(addr_in), 32'(last_wr));
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check({e.name, "_fail_count"}, 32'(fail_count), 32'(e.fc));
          check({e.name, "_fail_addr"},  32'(fail_addr),  32'(e.fa));
          check({e.name, "_pass"},       32'(pass),       32'(e.ps));
          check({e.name, "_busy_cycles"}, 32'(busy_cnt),  32'(e.cyc));
          check({e.name, "_addr_no_wrap"}, 32'(addr_in),  32'(LAST));
        end
      end
    end
    busy_prev = busy;
    done_prev = done;
  end

  // ---------------- driver ---------------------------------------------------
  task automatic clear_faults();
    for (int i = 0; i < 16; i++) begin
      and_m[i] = 16'hFFFF;
      or_m[i]  = 16'h0000;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge CLK); #1;
    end
    if (!done) check({name, "_done_timeout"}, 32'(done), 32'd1);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic run(input string name, input logic [15:0] fc, input logic [15:0] fa,
                     input logic ps, input bit extra_start);
    exp_t e;
    e.name = name; e.fc = fc; e.fa = fa; e.ps = ps; e.cyc = 3 * N * SWEEPS;
    sb.push_back(e);
    pulse_start();
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    check({name, "_done_cleared"},     32'(done), 32'd0);
    if (extra_start) begin
      repeat (4) @(posedge CLK);
      #1;
      pulse_start();
    end
    wait_done(name);
    check({name, "_done_held"}, 32'(done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem_out = 16'h0000;
    clear_faults();
    RST   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // Reset state
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_memW",       32'(memW),       32'd0);
    check("rst_memR",       32'(memR),       32'd0);
    check("rst_addr",       32'(addr_in),    32'd0);
    check("rst_dataW",      32'(dataW_in),   32'd0);
    check("rst_fail_count", 32'(fail_count), 32'd0);
    check("rst_fail_addr",  32'(fail_addr),  32'd0);
    check("rst_pass",       32'(pass),       32'd1);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Ideal memory
    run("ideal", 16'd0, 16'd0, 1'b1, 1'b0);

    // Bit0 stuck-at-0 at addr 2 (ABCD has bit0=1; ~ABCD has bit0=0)
    and_m[2] = 16'hFFFE;
    run("sa0_addr2", 16'd1, 16'd2, 1'b0, 1'b0);

    // Failures at addrs 1 and 3; the first failing address is kept
    clear_faults();
    and_m[1] = 16'hFFFE;
    and_m[3] = 16'hFFFE;
    run("fail_1_3", 16'd2, 16'd1, 1'b0, 1'b0);

    // Every address reads all-ones
    clear_faults();
    for (int i = 0; i < N; i++) or_m[i] = 16'hFFFF;
    run("all_fail", 16'(N * SWEEPS), 16'd0, 1'b0, 1'b0);

    // Bit15 stuck-at-1 at addr 0: only an inverted sweep (5432) can see it
    clear_faults();
    or_m[0] = 16'h8000;
`ifdef MEM_BIST_INVERT_PASS_EN
    run("sa1_bit15", 16'd1, 16'd0, 1'b0, 1'b0);
`else
    run("sa1_bit15", 16'd0, 16'd0, 1'b1, 1'b0);
`endif

    // Start pulsed while busy is ignored; the run length stays the same
    clear_faults();
    run("start_while_busy", 16'd0, 16'd0, 1'b1, 1'b1);

    // Reset during READ of addr 2 aborts the run
    pulse_start();
    for (int i = 0; i < 50 && !(memR && addr_in == 16'd2); i++) begin
      @(posedge CLK); #1;
    end
    check("abort_reached_read2", 32'(memR && addr_in == 16'd2), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("abort_memR", 32'(memR),    32'd0);
    check("abort_memW", 32'(memW),    32'd0);
    check("abort_busy", 32'(busy),    32'd0);
    check("abort_done", 32'(done),    32'd0);
    check("abort_addr", 32'(addr_in), 32'd0);

    // Start and reset in the same cycle: reset wins
    start = 1'b1;
    @(posedge CLK); #1;
    RST   = 1'b0;
    start = 1'b0;
    check("rst_wins_busy", 32'(busy), 32'd0);
    @(posedge CLK); #1;
    check("rst_wins_still_idle", 32'(busy), 32'd0);
    check("rst_wins_no_write",   32'(memW), 32'd0);

    // Clean run after the abort
    run("after_abort", 16'd0, 16'd0, 1'b1, 1'b0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard time bound in case the flow above stalls
  initial begin
    #200000;
    $display("FAIL global_timeout: got stalled run, expected completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mem_bist.md
MEM_BIST -- requirements
Module: mem_bist

Interface
REQ-001 Parameter ADDR_LAST, default 16'h1FFF, last word address tested; the sweep always starts at 16'h0000.
REQ-002 Parameter PATTERN, default 16'hABCD, data word written and expected on the first sweep.
REQ-003 CLK  input  1  clock; all logic on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a test run.
REQ-006 busy  output  1  high while a run is in progress.
REQ-007 done  output  1  high from run completion until the next accepted start or RST.
REQ-008 pass  output  1  valid while done=1; high iff fail_count==0.
REQ-009 fail_count  output  16  number of miscompares in the current or last run; saturates at 16'hFFFF.
REQ-010 fail_addr  output  16  address of the first miscompare in the run; 16'h0000 if none.
REQ-011 memW  output  1  memory write enable.
REQ-012 memR  output  1  memory read enable.
REQ-013 addr_in  output  16  memory address.
REQ-014 dataW_in  output  16  memory write data.
REQ-015 mem_out  input  16  memory read data, valid the cycle after the memR cycle.

Function
REQ-016 FSM states are IDLE, WRITE, READ, CHECK and FIN, and no other states exist.
REQ-017 IDLE: on start=1, clear fail_count, fail_addr and done, set addr_in=0 and sweep=0, then go to WRITE.
REQ-018 WRITE (1 cycle): memW=1, memR=0, dataW_in=current pattern, then go to READ.
REQ-019 READ (1 cycle): memW=0, memR=1, addr_in unchanged, then go to CHECK.
REQ-020 CHECK (1 cycle): memW=0, memR=0; compare mem_out against the current pattern.
REQ-021 On a miscompare in CHECK, increment fail_count (saturating at 16'hFFFF), and capture addr_in into fail_addr only if fail_count was 0.
REQ-022 From CHECK with addr_in!=ADDR_LAST: increment addr_in and go to WRITE.
REQ-023 From CHECK with addr_in==ADDR_LAST, and no further sweep configured: go to FIN; addr_in SHALL NOT wrap to 0, including when ADDR_LAST=16'hFFFF.
REQ-024 FIN (1 cycle): busy goes to 0 and done goes to 1, then go to IDLE.
REQ-025 Latency: exactly 3 cycles per address per sweep, plus 1 FIN cycle; busy is high from the cycle after start until FIN.
REQ-026 A start asserted while busy=1 SHALL be ignored.
REQ-027 memW and memR SHALL never be high in the same cycle, and both SHALL be 0 outside WRITE and READ.
REQ-028 If start=1 and RST=1 occur in the same cycle, RST wins.

Reset
REQ-029 RST=1 at a clock edge forces IDLE, busy=0, done=0, memW=0, memR=0, addr_in=0, dataW_in=0, fail_count=0 and fail_addr=0; pass then reads 1 but is meaningful only when done=1.
REQ-030 RST applied mid-run aborts the run, with no FIN and no done; memW and memR are low from the cycle after the reset edge.

Configuration
REQ-031 The macro MEM_BIST_INVERT_PASS_EN controls a second, inverted sweep.
REQ-032 With the macro defined: after the first sweep reaches ADDR_LAST in CHECK, set sweep=1, set addr_in=0 and return to WRITE with pattern ~PATTERN; FIN follows only after sweep 1 completes, and fail_count accumulates across both sweeps.
REQ-033 Without the macro defined: a single sweep using PATTERN, no sweep state, and the run length is (ADDR_LAST+1)*3+1 cycles.

Verification
REQ-034 Ideal memory, ADDR_LAST=3, start pulse -> WRITE/READ/CHECK for addr 0..3 in 12 cycles, FIN, done=1, pass=1, fail_count=0.
REQ-035 Memory with bit0 stuck-at-0 at addr 2 and PATTERN=16'hABCD, ADDR_LAST=3 -> fail_count=1, fail_addr=2, pass=0.
REQ-036 Memory failing at addrs 1 and 3 -> fail_count=2 and fail_addr=1 (the first failure is kept).
REQ-037 RST asserted during READ of addr 2 -> next cycle IDLE, memR=0, busy=0, done=0; a new start then runs cleanly from addr 0.
REQ-038 start pulsed again while busy=1 -> ignored, and the run length is unchanged.
REQ-039 With MEM_BIST_INVERT_PASS_EN defined, ADDR_LAST=1 and bit15 stuck-at-1 at addr 0 -> only the second sweep (16'h5432) fails, giving fail_count=1, fail_addr=0, and a run of 13 cycles.
